// File: rtl/shift_pipe_pkg.sv
// Shared types for the shift_pipe barrel shifter: shift encodings and the
// decoded-operation record that travels down the pipeline.
package shift_pipe_pkg;

  localparam int MAX_WIDTH = 64;
  localparam int ROT_W     = $clog2(MAX_WIDTH);
  localparam int CNT_W     = ROT_W + 1;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  // Controls for the mask/fill step; cnt is the number of bits masked or filled.
  typedef struct packed {
    sh_type_e         typ;
    logic [CNT_W-1:0] cnt;
    logic             pass;
    logic             rrx;
    logic             over;
    logic             sign;
    logic             cin;
  } ctl_t;

  typedef struct packed {
    logic [ROT_W-1:0] rot;
    ctl_t             ctl;
  } dec_op_t;

endpackage

// File: rtl/pipe_reg.sv
// One valid/ready pipeline register carrying an arbitrary packed payload.
module pipe_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  logic r_valid;
  T     r_data;
  logic w_adv;

  assign w_adv   = !r_valid || i_ready;
  assign o_ready = w_adv;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the payload is reset as well so the visible outputs read zero during reset.
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined shifter: decode -> rotate -> mask/fill, with 1..3 register stages
// and valid/ready flow control plus flush.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int AMT_W       = 8,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         rm,
  input  logic [1:0]               sh,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [AMT_W-1:0]         rs_amt,
  input  logic                     amt_is_reg,
  input  logic                     bypass,
  input  logic                     carry_in,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         result,
  output logic                     carry_out
);

  localparam int LG = $clog2(WIDTH);
  localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

  typedef struct packed { dec_op_t op;  logic [WIDTH-1:0] rm;  } dec_pl_t;
  typedef struct packed { ctl_t    ctl; logic [WIDTH-1:0] val; } rot_pl_t;
  typedef struct packed { logic [WIDTH-1:0] res; logic c;      } out_pl_t;

  sh_type_e         w_sh;
  logic             w_imm_zero;
  logic [AMT_W-1:0] w_n;
  logic [LG-1:0]    w_neg;
  dec_pl_t          w_dec;

  assign w_sh = sh_type_e'(sh);

  // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
  always_comb begin
    w_dec      = '0;
    w_imm_zero = !amt_is_reg && (shamt == '0);
    w_n        = amt_is_reg ? rs_amt : AMT_W'(shamt);
    if (w_imm_zero && (w_sh == SH_LSR || w_sh == SH_ASR)) w_n = W_AMT;
    w_neg = -w_n[LG-1:0];

    w_dec.rm           = rm;
    w_dec.op.ctl.typ   = w_sh;
    w_dec.op.ctl.cin   = carry_in;
    w_dec.op.ctl.sign  = rm[WIDTH-1];
    w_dec.op.ctl.pass  = bypass || (w_n == '0 && (amt_is_reg || w_sh == SH_LSL));
    w_dec.op.ctl.rrx   = !bypass && w_imm_zero && w_sh == SH_ROR;
    w_dec.op.ctl.over  = w_n > W_AMT;
    w_dec.op.ctl.cnt   = w_dec.op.ctl.over ? CNT_W'(WIDTH) : CNT_W'(w_n);

    // Left shifts become a right rotate by the complement, then a low mask.
    if (w_dec.op.ctl.pass || (w_sh != SH_ROR && w_n >= W_AMT)) w_dec.op.rot = '0;
    else if (w_dec.op.ctl.rrx)                                 w_dec.op.rot = ROT_W'(1);
    else if (w_sh == SH_LSL)                                   w_dec.op.rot = ROT_W'(w_neg);
    else                                                       w_dec.op.rot = ROT_W'(w_n[LG-1:0]);
  end

  logic    w_in_ready_raw;
  logic    w_a_valid, w_a_ready;
  dec_pl_t w_a_data;

  if (PIPE_STAGES >= 2) begin : g_dec_reg
    pipe_reg #(.T(dec_pl_t)) u_dec_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (flush),
      .i_valid (in_valid),
      .o_ready (w_in_ready_raw),
      .i_data  (w_dec),
      .o_valid (w_a_valid),
      .i_ready (w_a_ready),
      .o_data  (w_a_data)
    );
  end else begin : g_dec_comb
    assign w_a_valid      = in_valid;
    assign w_a_data       = w_dec;
    assign w_in_ready_raw = w_a_ready;
  end

  rot_pl_t w_rot;

  always_comb begin
    w_rot     = '0;
    w_rot.ctl = w_a_data.op.ctl;
    w_rot.val = WIDTH'({w_a_data.rm, w_a_data.rm} >> w_a_data.op.rot);
  end

  logic    w_b_valid, w_b_ready;
  rot_pl_t w_b_data;

  if (PIPE_STAGES == 3) begin : g_rot_reg
    pipe_reg #(.T(rot_pl_t)) u_rot_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .i_flush (flush),
      .i_valid (w_a_valid),
      .o_ready (w_a_ready),
      .i_data  (w_rot),
      .o_valid (w_b_valid),
      .i_ready (w_b_ready),
      .o_data  (w_b_data)
    );
  end else begin : g_rot_comb
    assign w_b_valid = w_a_valid;
    assign w_b_data  = w_rot;
    assign w_a_ready = w_b_ready;
  end

  logic [WIDTH-1:0] w_lo_keep, w_hi_keep;
  out_pl_t          w_out;

  always_comb begin
    w_lo_keep = {WIDTH{1'b1}} << w_b_data.ctl.cnt;
    w_hi_keep = {WIDTH{1'b1}} >> w_b_data.ctl.cnt;
    w_out     = '0;
    case (w_b_data.ctl.typ)
      SH_LSL: begin
        w_out.res = w_b_data.val & w_lo_keep;
        w_out.c   = !w_b_data.ctl.over && w_b_data.val[0];
      end
      SH_LSR: begin
        w_out.res = w_b_data.val & w_hi_keep;
        w_out.c   = !w_b_data.ctl.over && w_b_data.val[WIDTH-1];
      end
      SH_ASR: begin
        w_out.res = w_b_data.ctl.sign ? (w_b_data.val | ~w_hi_keep) : (w_b_data.val & w_hi_keep);
        w_out.c   = w_b_data.val[WIDTH-1];
      end
      default: begin
        w_out.res = w_b_data.ctl.rrx ? {w_b_data.ctl.cin, w_b_data.val[WIDTH-2:0]} : w_b_data.val;
        w_out.c   = w_b_data.val[WIDTH-1];
      end
    endcase
    if (w_b_data.ctl.pass) begin
      w_out.res = w_b_data.val;
      w_out.c   = w_b_data.ctl.cin;
    end
  end

  out_pl_t w_q;

  pipe_reg #(.T(out_pl_t)) u_out_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .i_flush (flush),
    .i_valid (w_b_valid),
    .o_ready (w_b_ready),
    .i_data  (w_out),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (w_q)
  );

  assign in_ready  = w_in_ready_raw && !flush;
  assign result    = w_q.res;
  assign carry_out = w_q.c;

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; power of two, 8..64.
REQ-002 SHALL have parameter AMT_W, default 8, register-specified shift-amount width; at least log2(WIDTH)+1.
REQ-003 SHALL have parameter PIPE_STAGES, default 2, registered stages; legal values 1..3.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted when in_valid and in_ready are both high.
REQ-008 rm  input  WIDTH  operand.
REQ-009 sh  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX.
REQ-010 shamt  input  log2(WIDTH)  immediate shift amount.
REQ-011 rs_amt  input  AMT_W  register shift amount.
REQ-012 amt_is_reg  input  1  use rs_amt instead of shamt.
REQ-013 bypass  input  1  pass rm unchanged (immediate operand, non-shift op).
REQ-014 carry_in  input  1  current C flag.
REQ-015 flush  input  1  discard all in-flight operations.
REQ-016 out_valid  output  1  result present.
REQ-017 out_ready  input  1  consumer accepts result.
REQ-018 result  output  WIDTH  shifted value.
REQ-019 carry_out  output  1  shifter carry per REQ-022..REQ-027.

Function
REQ-020 Datapath SHALL be ordered decode -> rotate -> mask/fill. An output register SHALL always exist. PIPE_STAGES>=2 SHALL add a register after decode. PIPE_STAGES=3 SHALL also add a register after rotate.
REQ-021 Effective amount n SHALL be rs_amt when amt_is_reg, else shamt; bypass=1 -> result=rm, carry_out=carry_in.
REQ-022 LSL: n=0 -> rm, carry_in; 1<=n<=WIDTH -> rm<<n, carry rm[WIDTH-n]; n>WIDTH -> 0, carry 0.
REQ-023 LSR: immediate n=0 SHALL mean n=WIDTH; register n=0 -> rm, carry_in; 1<=n<=WIDTH -> rm>>n, carry rm[n-1]; n>WIDTH -> 0, carry 0.
REQ-024 ASR: immediate n=0 SHALL mean n=WIDTH; register n=0 -> rm, carry_in; n>=WIDTH -> all bits rm[WIDTH-1], carry rm[WIDTH-1]; otherwise arithmetic shift, carry rm[n-1].
REQ-025 RRX (sh=11, immediate, n=0): result {carry_in, rm[WIDTH-1:1]}, carry rm[0].
REQ-026 ROR register: n=0 -> rm, carry_in; n!=0 and n mod WIDTH=0 -> rm, carry rm[WIDTH-1]; else rotate right by n mod WIDTH, carry result[WIDTH-1].
REQ-027 ROR immediate n!=0: rotate right by n, carry result[WIDTH-1].
REQ-028 Latency SHALL be exactly PIPE_STAGES cycles from acceptance to out_valid with no backpressure; throughput one operation per cycle.
REQ-029 Each stage SHALL advance when it is empty or its successor advances; the last stage advances when out_valid is low or out_ready is high.
REQ-030 in_ready SHALL equal (first stage empty or advancing) and not flush; in_ready SHALL be combinationally independent of in_valid.
REQ-031 While out_valid=1 and out_ready=0, result, carry_out and out_valid SHALL hold stable.
REQ-032 Operations SHALL leave in acceptance order; none dropped or duplicated except by flush.
REQ-033 flush SHALL clear every stage valid at the next edge, accept nothing that cycle, and take priority over simultaneous acceptance and output.
REQ-034 Decode SHALL capture carry_in at acceptance; later changes SHALL not affect in-flight operations.

Reset
REQ-035 reset_n low SHALL immediately clear all stage valids, out_valid=0, result=0, carry_out=0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight operations. in_ready SHALL be 1 from the first edge after release.

Structure
REQ-037 Package shift_pipe_pkg SHALL hold enum sh_type_e {SH_LSL, SH_LSR, SH_ASR, SH_ROR} and the decoded-operation struct (amount, type, special-case flags, captured carry).
REQ-038 One sub-module pipe_reg SHALL implement a valid/ready register stage parameterised by payload type. It SHALL be instantiated once per stage.

Verification
REQ-039 WIDTH=32, LSL register n=32, rm=0x00000001, carry_in=0 -> result 0, carry 1; n=33 -> result 0, carry 0.
REQ-040 ASR immediate shamt=0, rm=0x80000000 -> result 0xFFFFFFFF, carry 1; LSR immediate shamt=0, same rm -> 0, carry 1.
REQ-041 RRX rm=0x00000003, carry_in=1 -> 0x80000001, carry 1; ROR register n=64, rm=0x80000000 -> 0x80000000, carry 1.
REQ-042 PIPE_STAGES=3, back-to-back 8 ops with out_ready toggling every cycle -> all 8 results in order, outputs stable while stalled.
REQ-043 flush asserted with 2 ops in flight and in_valid high -> no out_valid next cycle, no acceptance that cycle, next op latency PIPE_STAGES.
REQ-044 reset_n pulsed low mid-stream -> out_valid drops asynchronously, result 0, stream restarts cleanly.
